uart_echo_fifo: RTL
===================

UART_ECHO_FIFO -- requirements
Module: uart_echo_fifo

Interface
REQ-001 Parameter DEPTH_LOG2, default 4: FIFO holds 2**DEPTH_LOG2 bytes; legal range 1..8.
REQ-002 Parameter LED_MODE, default 0: 0 = led shows last received byte; 1 = led shows FIFO level, zero-extended or truncated to 8 bits.
REQ-003 clk_25mhz  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 rx_data  input  8  byte from the UART receiver, valid when rx_ready=1.
REQ-006 rx_ready  input  1  one-cycle strobe: rx_data valid this cycle.
REQ-007 tx_busy  input  1  UART transmitter busy.
REQ-008 tx_start  output  1  one-cycle start pulse to the transmitter.
REQ-009 tx_data  output  8  byte to transmit; stable from tx_start until the next tx_start.
REQ-010 led  output  8  status display per LED_MODE.
REQ-011 level  output  DEPTH_LOG2+1  current FIFO occupancy, 0..2**DEPTH_LOG2.
REQ-012 overflow  output  1  sticky: set on any dropped byte; cleared only by reset.
REQ-013 drop_cnt  output  8  count of dropped bytes; saturates at 255.

Function
REQ-014 Circular FIFO with registered write/read pointers, each DEPTH_LOG2+1 bits; full = pointers equal except MSB; empty = pointers equal.
REQ-015 Push: on rx_ready=1 with FIFO not full at cycle start, write rx_data at wr_ptr and increment wr_ptr modulo 2**(DEPTH_LOG2+1).
REQ-016 Drop: on rx_ready=1 with FIFO full at cycle start, discard byte, leave the FIFO unchanged, set overflow, increment drop_cnt unless it equals 255; drop is decided before any same-cycle pop.
REQ-017 last_rx register updates to rx_data on every rx_ready, including dropped bytes.
REQ-018 Tx FSM states: IDLE, HOLD, WAIT.
REQ-019 IDLE: if FIFO not empty and tx_busy=0 -> register tx_data=mem[rd_ptr], assert tx_start next cycle, increment rd_ptr, go HOLD; else stay.
REQ-020 HOLD: tx_start=0; tx_busy ignored for this one cycle; go WAIT.
REQ-021 WAIT: stay while tx_busy=1; go IDLE when tx_busy=0.
REQ-022 tx_start is high for exactly one cycle per popped byte and never high in two consecutive cycles.
REQ-023 Latency: with the FIFO empty, the FSM in IDLE and tx_busy=0, rx_ready in cycle N -> tx_start high in cycle N+2.
REQ-024 Simultaneous push and pop in one cycle: both take effect; level unchanged.
REQ-025 A byte pushed into an empty FIFO is not popped in the same cycle.
REQ-026 Bytes are transmitted in arrival order; no byte is duplicated.
REQ-027 level = wr_ptr - rd_ptr, registered, updated the same cycle as the pointers.

Reset
REQ-028 With rst_n=0: pointers, level, last_rx, tx_data, drop_cnt = 0; tx_start = 0; overflow = 0; FSM = IDLE; led = 0.
REQ-029 Reset mid-transfer abandons all queued bytes; after rst_n rises, no tx_start is issued until a new rx_ready.
REQ-030 FIFO storage is not reset; stale contents are unreachable because pointers are equal.

Configuration
REQ-031 Macro ECHO_CRLF_EN defined: a received 0x0D pushes 0x0D then 0x0A in one cycle (writes at wr_ptr and wr_ptr+1, wr_ptr += 2); this requires 2 free entries, otherwise both bytes are dropped and drop_cnt increments by 1.
REQ-032 Macro ECHO_CRLF_EN undefined: 0x0D is treated like any other byte; no second write port is generated.

Verification
REQ-033 Reset, then rx 0x41 with tx_busy=0 -> tx_start in cycle N+2, tx_data=0x41, level returns to 0.
REQ-034 Hold tx_busy=1, push 0x01..0x10 (DEPTH_LOG2=4) -> level=16, overflow=0; push 0x11 -> dropped, overflow=1, drop_cnt=1; release busy -> 0x01..0x10 sent in order.
REQ-035 Push 300 bytes into a full FIFO -> drop_cnt saturates at 255.
REQ-036 tx_busy toggles 1 cycle after each tx_start and stays high 10 cycles; 3 queued bytes -> 3 starts, each following busy deassertion, with no double start.
REQ-037 ECHO_CRLF_EN defined, rx 0x0D with FIFO empty -> 0x0D then 0x0A transmitted; with 1 free entry -> both dropped, drop_cnt += 1.
REQ-038 rst_n pulsed low with level=5 mid-WAIT -> all outputs 0 at once; no further tx_start until new input.

Source files
------------

// File: rtl/uart_echo_fifo.sv
// UART echo buffer: received bytes are queued in a circular FIFO and replayed to the transmitter.
// Optional `ECHO_CRLF_EN: a received CR is stored as CR followed by LF in a single cycle.
module uart_echo_fifo #(
    parameter int unsigned DEPTH_LOG2 = 4,
    parameter int unsigned LED_MODE   = 0
) (
    input  logic                  clk_25mhz,
    input  logic                  rst_n,
    input  logic [7:0]            rx_data,
    input  logic                  rx_ready,
    input  logic                  tx_busy,
    output logic                  tx_start,
    output logic [7:0]            tx_data,
    output logic [7:0]            led,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  overflow,
    output logic [7:0]            drop_cnt
);

    localparam int unsigned     PtrW   = DEPTH_LOG2 + 1;
    localparam int unsigned     Depth  = 1 << DEPTH_LOG2;
    localparam logic [PtrW-1:0] PtrOne = PtrW'(1);

    typedef enum logic [1:0] {StIdle, StHold, StWait} tx_state_e;

    tx_state_e state_q, state_d;

    logic [7:0]            mem [Depth];
    logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0]       level_q;
    logic [DEPTH_LOG2-1:0] wr_idx, rd_idx;
    logic                  full, empty;
    logic                  push, drop, pop;
    logic                  tx_start_q, tx_start_d;
    logic [7:0]            tx_data_q;
    logic [7:0]            last_rx_q;
    logic [7:0]            drop_cnt_q;
    logic                  overflow_q;

    assign wr_idx = wr_ptr_q[DEPTH_LOG2-1:0];
    assign rd_idx = rd_ptr_q[DEPTH_LOG2-1:0];
    assign full   = (wr_ptr_q[PtrW-1] != rd_ptr_q[PtrW-1]) && (wr_idx == rd_idx);
    assign empty  = (wr_ptr_q == rd_ptr_q);

`ifdef ECHO_CRLF_EN
    localparam logic [PtrW-1:0] PtrTwo     = PtrW'(2);
    localparam logic [PtrW-1:0] CrlfMaxLvl = PtrW'(Depth - 1);

    logic                  is_cr;
    logic                  crlf_room;
    logic [DEPTH_LOG2-1:0] wr_idx_inc;

    assign is_cr      = (rx_data == 8'h0D);
    // CR+LF needs two free entries; otherwise the pair is dropped as one event
    assign crlf_room  = (level_q < CrlfMaxLvl);
    assign wr_idx_inc = wr_idx + DEPTH_LOG2'(1);
    assign push       = rx_ready && (is_cr ? crlf_room : !full);
`else
    assign push       = rx_ready && !full;
`endif

    assign drop = rx_ready && !push;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        if (push) begin
`ifdef ECHO_CRLF_EN
            wr_ptr_d = wr_ptr_q + (is_cr ? PtrTwo : PtrOne);
`else
            wr_ptr_d = wr_ptr_q + PtrOne;
`endif
        end
    end

    assign rd_ptr_d = pop ? (rd_ptr_q + PtrOne) : rd_ptr_q;

    // Storage is deliberately not reset; equal pointers make stale data unreachable
    always_ff @(posedge clk_25mhz) begin
        if (push) begin
            mem[wr_idx] <= rx_data;
`ifdef ECHO_CRLF_EN
            if (is_cr) begin
                mem[wr_idx_inc] <= 8'h0A;
            end
`endif
        end
    end

    always_ff @(posedge clk_25mhz or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (!empty && !tx_busy) state_d = StHold;
            StHold:  state_d = StWait;
            StWait:  if (!tx_busy) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Emptiness is taken at cycle start, so a byte pushed this cycle cannot be popped yet
    always_comb begin
        pop        = (state_q == StIdle) && !empty && !tx_busy;
        tx_start_d = pop;
    end

    always_ff @(posedge clk_25mhz or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            tx_start_q <= 1'b0;
            tx_data_q  <= 8'h00;
            last_rx_q  <= 8'h00;
            overflow_q <= 1'b0;
            drop_cnt_q <= 8'h00;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= wr_ptr_d - rd_ptr_d;
            tx_start_q <= tx_start_d;
            if (pop) begin
                tx_data_q <= mem[rd_idx];
            end
            if (rx_ready) begin
                last_rx_q <= rx_data;
            end
            if (drop) begin
                overflow_q <= 1'b1;
                if (drop_cnt_q != 8'hFF) begin
                    drop_cnt_q <= drop_cnt_q + 8'd1;
                end
            end
        end
    end

    generate
        if (LED_MODE == 1) begin : g_led_level
            if (PtrW >= 8) begin : g_trunc
                assign led = level_q[7:0];
            end else begin : g_ext
                assign led = {{(8 - PtrW){1'b0}}, level_q};
            end
        end else begin : g_led_last
            assign led = last_rx_q;
        end
    endgenerate

    assign tx_start = tx_start_q;
    assign tx_data  = tx_data_q;
    assign level    = level_q;
    assign overflow = overflow_q;
    assign drop_cnt = drop_cnt_q;

endmodule
